// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like port arbiter: requester identity, owner FIFO entry, hold register.
package sram_like_arbiter_pkg;

  typedef enum logic {
    OwnerInst = 1'b0,
    OwnerData = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   discard;
  } fifo_entry_t;

  typedef struct packed {
    owner_e      owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        discard;
  } hold_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order record of who issued each accepted request; cancel marks every INST entry as discarded.
module sram_like_arbiter_owner_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  fifo_entry_t     push_entry,
  input  logic            pop,
  input  logic            cancel_inst,
  output logic [CntW-1:0] count,
  output logic            empty,
  output fifo_entry_t     head
);

  fifo_entry_t     mem_q [Depth];
  fifo_entry_t     mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_eff;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop against an empty FIFO leaves the pointers alone; the top flags it.
  assign pop_eff = pop & (count_q != '0);

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < Depth; i++) begin
      if (cancel_inst && mem_d[i].owner == OwnerInst) mem_d[i].discard = 1'b1;
    end
    if (push) mem_d[wr_ptr_q] = push_entry;

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push, pop_eff})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between fetch (inst_*) and memory-stage (data_*) requesters.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

  hold_t           hold_q, hold_d, sel;
  logic            hold_valid_q, hold_valid_d;
  logic            arb_err_q, arb_err_d;
  logic            issue_ok, live_req, accept;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  fifo_entry_t     fifo_head, push_entry;

  assign issue_ok = (fifo_count < CntW'(OUTSTANDING));

  // A pending hold always owns the port; otherwise data side has priority.
  always_comb begin
    sel      = hold_q;
    live_req = 1'b0;
    if (!hold_valid_q && issue_ok) begin
      if (data_req) begin
        sel      = '{owner: OwnerData, wr: data_wr, size: data_size, addr: data_addr,
                     wdata: data_wdata, discard: 1'b0};
        live_req = 1'b1;
      end else if (inst_req) begin
        sel      = '{owner: OwnerInst, wr: inst_wr, size: inst_size, addr: inst_addr,
                     wdata: inst_wdata, discard: 1'b0};
        live_req = 1'b1;
      end
    end
  end

  assign mem_req   = ~reset & (hold_valid_q | live_req);
  assign mem_wr    = sel.wr;
  assign mem_size  = sel.size;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign accept    = mem_req & mem_addr_ok;

  assign inst_addr_ok = accept & (sel.owner == OwnerInst);
  assign data_addr_ok = accept & (sel.owner == OwnerData);

  always_comb begin
    push_entry.owner   = sel.owner;
    push_entry.discard = sel.discard | (inst_cancel & (sel.owner == OwnerInst));
  end

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (hold_valid_q && inst_cancel && hold_q.owner == OwnerInst) hold_d.discard = 1'b1;
    if (live_req && !mem_addr_ok) begin
      hold_valid_d   = 1'b1;
      hold_d         = sel;
      hold_d.discard = push_entry.discard;
    end
    if (accept) hold_valid_d = 1'b0;
    arb_err_d = arb_err_q | (mem_data_ok & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      arb_err_q    <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      arb_err_q    <= arb_err_d;
    end
  end

  sram_like_arbiter_owner_fifo #(
    .Depth (OUTSTANDING)
  ) u_owner_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (accept),
    .push_entry  (push_entry),
    .pop         (mem_data_ok),
    .cancel_inst (inst_cancel),
    .count       (fifo_count),
    .empty       (fifo_empty),
    .head        (fifo_head)
  );

  assign inst_data_ok = ~reset & mem_data_ok & ~fifo_empty & (fifo_head.owner == OwnerInst) &
                        ~fifo_head.discard & ~inst_cancel;
  assign data_data_ok = ~reset & mem_data_ok & ~fifo_empty & (fifo_head.owner == OwnerData);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_err      = arb_err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: expected responses queued at stimulus time, checked by an independent monitor.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_cancel;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        arb_err;

  int checks   = 0;
  int failures = 0;
  int pulses;

  typedef struct {
    logic        is_inst;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  sram_like_arbiter #(
    .OUTSTANDING (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_cancel  (inst_cancel),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .arb_err      (arb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic is_inst, input logic [31:0] rdata);
    exp_t e;
    e.is_inst = is_inst;
    e.rdata   = rdata;
    exp_q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  // Monitor: every response the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && (inst_data_ok || data_data_ok)) begin
      if (inst_data_ok && data_data_ok) begin
        checks++;
        failures++;
        $display("FAIL both_data_ok: got inst=1 data=1 required only one");
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got inst=%0b data=%0b rdata=%h required none",
                 inst_data_ok, data_data_ok, mem_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_owner_inst", 32'(inst_data_ok), 32'(mon_e.is_inst));
        chk("rsp_rdata", inst_data_ok ? inst_rdata : data_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    idle();
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 0);
    next(); next();
    reset = 0; idle();
    @(negedge clk);
    chk("rst_arb_err", 32'(arb_err), 0);
    chk("idle_mem_req", 32'(mem_req), 0);

    // Data priority, inst accepted the following cycle.
    next(); inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; mem_addr_ok = 1;
    @(negedge clk);
    chk("prio_data_addr_ok", 32'(data_addr_ok), 1);
    chk("prio_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("prio_mem_addr", mem_addr, 32'h200);
    next(); data_req = 0;
    @(negedge clk);
    chk("prio_inst_next", 32'(inst_addr_ok), 1);
    chk("prio_inst_addr", mem_addr, 32'h100);

    // Credit limit with two outstanding; no same-cycle credit from a pop.
    next();
    @(negedge clk);
    chk("full_mem_req", 32'(mem_req), 0);
    chk("full_inst_addr_ok", 32'(inst_addr_ok), 0);
    next(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hA1; expect_rsp(0, 32'hA1);
    @(negedge clk);
    chk("pop_same_cycle_mem_req", 32'(mem_req), 0);
    next(); mem_addr_ok = 1; mem_rdata = 32'hA2; expect_rsp(1, 32'hA2);
    @(negedge clk);
    chk("credit_back_mem_req", 32'(mem_req), 1);
    chk("credit_back_addr_ok", 32'(inst_addr_ok), 1);
    next(); inst_req = 0; mem_addr_ok = 0; mem_rdata = 32'hA3; expect_rsp(1, 32'hA3);
    next(); idle();

    // Held request stays stable; hold outranks a later data request.
    pulses = 0;
    inst_req = 1; inst_addr = 32'hbfc00000;
    @(negedge clk);
    chk("hold_c1_mem_req", 32'(mem_req), 1);
    chk("hold_c1_mem_addr", mem_addr, 32'hbfc00000);
    pulses += int'(inst_addr_ok);
    for (int i = 0; i < 2; i++) begin
      next(); inst_req = 0; inst_addr = 32'hdeadbeef;
      data_req = (i == 1); data_addr = 32'h1000; data_wr = 1; data_size = 2'd1;
      @(negedge clk);
      chk("hold_mem_req", 32'(mem_req), 1);
      chk("hold_mem_addr", mem_addr, 32'hbfc00000);
      pulses += int'(inst_addr_ok);
    end
    next(); mem_addr_ok = 1;
    @(negedge clk);
    chk("hold_accept_addr", mem_addr, 32'hbfc00000);
    chk("hold_accept_inst_ok", 32'(inst_addr_ok), 1);
    chk("hold_accept_data_ok", 32'(data_addr_ok), 0);
    pulses += int'(inst_addr_ok);
    next();
    @(negedge clk);
    chk("after_hold_data_ok", 32'(data_addr_ok), 1);
    chk("after_hold_addr", mem_addr, 32'h1000);
    chk("after_hold_wr", 32'(mem_wr), 1);
    chk("after_hold_size", 32'(mem_size), 1);
    pulses += int'(inst_addr_ok);
    chk("hold_inst_pulses", pulses, 1);
    next(); idle(); mem_data_ok = 1; mem_rdata = 32'h55; expect_rsp(1, 32'h55);
    next(); mem_rdata = 32'h66; expect_rsp(0, 32'h66);
    next(); idle();

    // Cancel after INST and DATA are both in flight.
    inst_req = 1; inst_addr = 32'h300; mem_addr_ok = 1;
    next(); inst_req = 0; data_req = 1; data_addr = 32'h400;
    @(negedge clk);
    chk("cancel_setup_data_ok", 32'(data_addr_ok), 1);
    next(); idle(); inst_cancel = 1;
    next(); inst_cancel = 0; mem_data_ok = 1; mem_rdata = 32'h11;
    @(negedge clk);
    chk("cancelled_inst_data_ok", 32'(inst_data_ok), 0);
    next(); mem_rdata = 32'h22; expect_rsp(0, 32'h22);
    next(); idle();

    // Cancel coincident with an INST accept; the next INST is delivered.
    inst_req = 1; inst_addr = 32'h500; inst_cancel = 1; mem_addr_ok = 1;
    @(negedge clk);
    chk("cancel_accept_addr_ok", 32'(inst_addr_ok), 1);
    next(); inst_cancel = 0; inst_addr = 32'h504;
    @(negedge clk);
    chk("second_inst_addr_ok", 32'(inst_addr_ok), 1);
    next(); idle(); mem_data_ok = 1; mem_rdata = 32'h33;
    @(negedge clk);
    chk("same_cycle_cancel_suppressed", 32'(inst_data_ok), 0);
    next(); mem_rdata = 32'h44; expect_rsp(1, 32'h44);
    next(); idle();

    // Cancel while the INST request sits in the hold register.
    inst_req = 1; inst_addr = 32'h600;
    next(); inst_req = 0; inst_cancel = 1;
    next(); inst_cancel = 0; mem_addr_ok = 1;
    @(negedge clk);
    chk("held_cancel_addr_ok", 32'(inst_addr_ok), 1);
    next(); idle(); mem_data_ok = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("held_cancel_suppressed", 32'(inst_data_ok), 0);
    next(); idle();

    // Stray response sets a sticky error; reset clears it.
    mem_data_ok = 1; mem_rdata = 32'h99;
    next(); idle();
    @(negedge clk);
    chk("arb_err_set", 32'(arb_err), 1);
    next(); next();
    @(negedge clk);
    chk("arb_err_sticky", 32'(arb_err), 1);
    next(); reset = 1; inst_req = 1;
    @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 0);
    next(); reset = 0; inst_req = 0;
    @(negedge clk);
    chk("reset_arb_err", 32'(arb_err), 0);
    chk("reset_idle_mem_req", 32'(mem_req), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
